// File: rtl/ethernet_frame_receiver.sv
// Dibit Ethernet receiver: strips preamble/SFD, filters on destination MAC, emits payload bytes.
// Latency 1 clk from a byte's last dibit to axiov; no backpressure, the input stream never stalls.
module ethernet_frame_receiver #(
    parameter logic [47:0] MAC_ADDR            = 48'hF00DDEADBEEF,
    parameter bit          ACCEPT_BROADCAST    = 1'b1,
    parameter int          MIN_PREAMBLE_DIBITS = 16,
    parameter int          MAX_PAYLOAD         = 1500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        axiov,
    output logic [7:0]  axiod,
    output logic [15:0] ethertype,
    output logic        frame_done,
    output logic        frame_err,
    output logic [10:0] payload_len
);
    localparam logic [5:0]  MIN_PRE = 6'(MIN_PREAMBLE_DIBITS);
    localparam logic [10:0] MAX_PL  = 11'(MAX_PAYLOAD);

    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER_SFD, HEADER, PAYLOAD, DROP} state_t;

    state_t      state, state_nxt;
    logic [5:0]  pre_cnt, pre_cnt_nxt;
    logic [1:0]  phase, phase_nxt;
    logic [1:0]  sfd_cnt, sfd_cnt_nxt;
    logic [7:0]  shift_reg, shift_reg_nxt;
    logic [3:0]  hdr_cnt, hdr_cnt_nxt;
    logic [10:0] byte_cnt, byte_cnt_nxt;
    logic        dst_match, dst_match_nxt;
    logic        dst_bcast, dst_bcast_nxt;
    logic [7:0]  type_hi, type_hi_nxt;
    logic        axiov_nxt, frame_done_nxt, frame_err_nxt;
    logic [7:0]  axiod_nxt;
    logic [15:0] ethertype_nxt;
    logic [10:0] payload_len_nxt;

    logic [7:0]  byte_now;
    logic        byte_done;
    logic [47:0] mac_sh;
    logic        match_now, bcast_now;

    assign byte_now  = {shift_reg[5:0], axiid};
    assign byte_done = axiiv && (phase == 2'd3);
    // Destination byte hdr_cnt of MAC_ADDR lands in the top octet.
    assign mac_sh    = MAC_ADDR << {hdr_cnt, 3'b000};
    assign match_now = dst_match && (byte_now == mac_sh[47:40]);
    assign bcast_now = dst_bcast && (byte_now == 8'hFF);

    always_comb begin
        state_nxt       = state;
        pre_cnt_nxt     = pre_cnt;
        phase_nxt       = phase;
        sfd_cnt_nxt     = sfd_cnt;
        shift_reg_nxt   = axiiv ? byte_now : shift_reg;
        hdr_cnt_nxt     = hdr_cnt;
        byte_cnt_nxt    = byte_cnt;
        dst_match_nxt   = dst_match;
        dst_bcast_nxt   = dst_bcast;
        type_hi_nxt     = type_hi;
        axiov_nxt       = 1'b0;
        axiod_nxt       = axiod;
        ethertype_nxt   = ethertype;
        frame_done_nxt  = 1'b0;
        frame_err_nxt   = 1'b0;
        payload_len_nxt = payload_len;

        case (state)
            IDLE: begin
                if (axiiv) begin
                    if (axiid == 2'b01) begin
                        state_nxt   = PREAMBLE;
                        pre_cnt_nxt = 6'd1;
                    end else begin
                        state_nxt = DROP;
                    end
                end
            end
            PREAMBLE: begin
                if (!axiiv) begin
                    state_nxt = IDLE;
                end else if (axiid == 2'b01) begin
                    if (pre_cnt != 6'd63) pre_cnt_nxt = pre_cnt + 6'd1;
                end else if (axiid == 2'b11 && pre_cnt >= MIN_PRE) begin
                    state_nxt   = HEADER_SFD;
                    sfd_cnt_nxt = 2'd0;
                end else begin
                    state_nxt = DROP;
                end
            end
            HEADER_SFD: begin
                if (!axiiv) begin
                    state_nxt = IDLE;
                end else if (axiid != 2'b01) begin
                    state_nxt = DROP;
                end else if (sfd_cnt == 2'd2) begin
                    state_nxt     = HEADER;
                    phase_nxt     = 2'd0;
                    hdr_cnt_nxt   = 4'd0;
                    dst_match_nxt = 1'b1;
                    dst_bcast_nxt = 1'b1;
                end else begin
                    sfd_cnt_nxt = sfd_cnt + 2'd1;
                end
            end
            HEADER: begin
                if (!axiiv) begin
                    state_nxt     = IDLE;
                    frame_err_nxt = (hdr_cnt >= 4'd6);
                end else begin
                    phase_nxt = phase + 2'd1;
                    if (byte_done) begin
                        hdr_cnt_nxt = hdr_cnt + 4'd1;
                        if (hdr_cnt < 4'd6) begin
                            dst_match_nxt = match_now;
                            dst_bcast_nxt = bcast_now;
                        end
                        if (hdr_cnt == 4'd5 && !(match_now || (ACCEPT_BROADCAST && bcast_now)))
                            state_nxt = DROP;
                        if (hdr_cnt == 4'd12) type_hi_nxt = byte_now;
                        if (hdr_cnt == 4'd13) begin
                            ethertype_nxt = {type_hi, byte_now};
                            state_nxt     = PAYLOAD;
                            byte_cnt_nxt  = 11'd0;
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (!axiiv) begin
                    state_nxt = IDLE;
                    if (phase == 2'd0 && byte_cnt != 11'd0) begin
                        frame_done_nxt  = 1'b1;
                        payload_len_nxt = byte_cnt;
                    end else begin
                        frame_err_nxt = 1'b1;
                    end
                end else begin
                    phase_nxt = phase + 2'd1;
                    if (byte_done) begin
                        if (byte_cnt == MAX_PL) begin
                            frame_err_nxt = 1'b1;
                            state_nxt     = DROP;
                        end else begin
                            axiov_nxt    = 1'b1;
                            axiod_nxt    = byte_now;
                            byte_cnt_nxt = byte_cnt + 11'd1;
                        end
                    end
                end
            end
            DROP: begin
                if (!axiiv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pre_cnt     <= 6'd0;
            phase       <= 2'd0;
            sfd_cnt     <= 2'd0;
            shift_reg   <= 8'd0;
            hdr_cnt     <= 4'd0;
            byte_cnt    <= 11'd0;
            dst_match   <= 1'b0;
            dst_bcast   <= 1'b0;
            type_hi     <= 8'd0;
            axiov       <= 1'b0;
            axiod       <= 8'd0;
            ethertype   <= 16'd0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            payload_len <= 11'd0;
        end else begin
            state       <= state_nxt;
            pre_cnt     <= pre_cnt_nxt;
            phase       <= phase_nxt;
            sfd_cnt     <= sfd_cnt_nxt;
            shift_reg   <= shift_reg_nxt;
            hdr_cnt     <= hdr_cnt_nxt;
            byte_cnt    <= byte_cnt_nxt;
            dst_match   <= dst_match_nxt;
            dst_bcast   <= dst_bcast_nxt;
            type_hi     <= type_hi_nxt;
            axiov       <= axiov_nxt;
            axiod       <= axiod_nxt;
            ethertype   <= ethertype_nxt;
            frame_done  <= frame_done_nxt;
            frame_err   <= frame_err_nxt;
            payload_len <= payload_len_nxt;
        end
    end
endmodule

// File: tb/tb_ethernet_frame_receiver.sv
// Directed bench for ethernet_frame_receiver; a second instance has broadcast acceptance disabled.
module tb_ethernet_frame_receiver;
    logic        clk = 1'b0;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic        axiov, frame_done, frame_err;
    logic [7:0]  axiod;
    logic [15:0] ethertype;
    logic [10:0] payload_len;
    logic        nb_axiov, nb_frame_done, nb_frame_err;
    logic [7:0]  nb_axiod;
    logic [15:0] nb_ethertype;
    logic [10:0] nb_payload_len;

    int compared = 0;
    int mismatched = 0;

    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];
    int done_cnt = 0, err_cnt = 0, overlap_cnt = 0;
    int nb_rx_cnt = 0, nb_done_cnt = 0, nb_err_cnt = 0;

    ethernet_frame_receiver dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(axiov), .axiod(axiod), .ethertype(ethertype),
        .frame_done(frame_done), .frame_err(frame_err), .payload_len(payload_len)
    );

    ethernet_frame_receiver #(.ACCEPT_BROADCAST(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(nb_axiov), .axiod(nb_axiod), .ethertype(nb_ethertype),
        .frame_done(nb_frame_done), .frame_err(nb_frame_err), .payload_len(nb_payload_len)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (axiov) rx_q.push_back(axiod);
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
        if ((frame_done && frame_err) || (axiov && frame_done)) overlap_cnt++;
        if (nb_axiov) nb_rx_cnt++;
        if (nb_frame_done) nb_done_cnt++;
        if (nb_frame_err) nb_err_cnt++;
    end

    task automatic send_dibit(input logic [1:0] d);
        axiiv = 1'b1;
        axiid = d;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_dibit(b[7:6]);
        send_dibit(b[5:4]);
        send_dibit(b[3:2]);
        send_dibit(b[1:0]);
    endtask

    task automatic idle(input int n);
        axiiv = 1'b0;
        axiid = 2'b00;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int pre_n, input logic [47:0] dest, input logic [15:0] etype);
        repeat (pre_n) send_dibit(2'b01);
        send_byte(8'hD5);
        for (int i = 0; i < 6; i++) send_byte(dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) send_byte(8'(48'hF00DDEADBEEF >> (40 - 8*i)));
        send_byte(etype[15:8]);
        send_byte(etype[7:0]);
        foreach (tx_q[i]) send_byte(tx_q[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1; axiiv = 1'b0; axiid = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        compared++;
        if ({axiov, frame_done, frame_err} !== 3'b000) begin
            mismatched++; $display("FAIL reset_strobes: got %b expected 000", {axiov, frame_done, frame_err});
        end
        compared++;
        if (axiod !== 8'h00) begin mismatched++; $display("FAIL reset_axiod: got %h expected 00", axiod); end
        compared++;
        if (ethertype !== 16'h0000) begin mismatched++; $display("FAIL reset_ethertype: got %h expected 0000", ethertype); end
        compared++;
        if (payload_len !== 11'd0) begin mismatched++; $display("FAIL reset_payload_len: got %0d expected 0", payload_len); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_unicast();
        int r0 = rx_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        tx_q = '{8'hA5, 8'h3C};
        send_frame(28, 48'hF00DDEADBEEF, 16'h0800);
        compared++;
        if ({axiov, axiod} !== {1'b1, 8'h3C}) begin
            mismatched++; $display("FAIL unicast_latency: got v=%b d=%h expected v=1 d=3c", axiov, axiod);
        end
        idle(3);
        compared++;
        if (rx_q.size() - r0 !== 2) begin mismatched++; $display("FAIL unicast_count: got %0d expected 2", rx_q.size() - r0); end
        else begin
            compared++;
            if ({rx_q[r0], rx_q[r0+1]} !== 16'hA53C) begin
                mismatched++; $display("FAIL unicast_bytes: got %h %h expected a5 3c", rx_q[r0], rx_q[r0+1]);
            end
        end
        compared++;
        if (ethertype !== 16'h0800) begin mismatched++; $display("FAIL unicast_ethertype: got %h expected 0800", ethertype); end
        compared++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            mismatched++; $display("FAIL unicast_pulses: got done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0);
        end
        compared++;
        if (payload_len !== 11'd2) begin mismatched++; $display("FAIL unicast_len: got %0d expected 2", payload_len); end
    endtask

    task automatic test_filter();
        int r0 = rx_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        tx_q = '{8'hA5, 8'h3C};
        send_frame(28, 48'h112233445566, 16'h0800);
        idle(1);
        tx_q = '{8'h5A};
        send_frame(28, 48'hF00DDEADBEEF, 16'h0800);
        idle(3);
        compared++;
        if (rx_q.size() - r0 !== 1) begin mismatched++; $display("FAIL filter_count: got %0d expected 1", rx_q.size() - r0); end
        else begin
            compared++;
            if (rx_q[r0] !== 8'h5A) begin mismatched++; $display("FAIL filter_byte: got %h expected 5a", rx_q[r0]); end
        end
        compared++;
        if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            mismatched++; $display("FAIL filter_pulses: got done=%0d err=%0d expected 1 0", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_broadcast();
        int r0 = rx_q.size();
        int n0 = nb_rx_cnt;
        int nd0 = nb_done_cnt;
        int ne0 = nb_err_cnt;
        tx_q = '{8'h01, 8'h02, 8'h03};
        send_frame(28, 48'hFFFFFFFFFFFF, 16'h88B5);
        idle(3);
        compared++;
        if (rx_q.size() - r0 !== 3) begin mismatched++; $display("FAIL bcast_count: got %0d expected 3", rx_q.size() - r0); end
        else begin
            compared++;
            if ({rx_q[r0], rx_q[r0+1], rx_q[r0+2]} !== 24'h010203) begin
                mismatched++; $display("FAIL bcast_bytes: got %h %h %h expected 01 02 03", rx_q[r0], rx_q[r0+1], rx_q[r0+2]);
            end
        end
        compared++;
        if (payload_len !== 11'd3) begin mismatched++; $display("FAIL bcast_len: got %0d expected 3", payload_len); end
        compared++;
        if (ethertype !== 16'h88B5) begin mismatched++; $display("FAIL bcast_ethertype: got %h expected 88b5", ethertype); end
        compared++;
        if (nb_rx_cnt - n0 !== 0 || nb_done_cnt - nd0 !== 0 || nb_err_cnt - ne0 !== 0) begin
            mismatched++; $display("FAIL nobcast_quiet: got rx=%0d done=%0d err=%0d expected 0 0 0",
                                   nb_rx_cnt - n0, nb_done_cnt - nd0, nb_err_cnt - ne0);
        end
        compared++;
        if ({nb_payload_len, nb_ethertype} !== {11'd1, 16'h0800}) begin
            mismatched++; $display("FAIL nobcast_hold: got len=%0d type=%h expected 1 0800", nb_payload_len, nb_ethertype);
        end
    endtask

    task automatic test_preamble();
        int r0 = rx_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        tx_q = '{8'h77};
        send_frame(10, 48'hF00DDEADBEEF, 16'h0800);
        idle(3);
        compared++;
        if (rx_q.size() - r0 !== 0 || done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            mismatched++; $display("FAIL short_preamble: got rx=%0d done=%0d err=%0d expected 0 0 0",
                                   rx_q.size() - r0, done_cnt - d0, err_cnt - e0);
        end
        tx_q = '{8'h88};
        send_frame(16, 48'hF00DDEADBEEF, 16'h0800);
        idle(3);
        compared++;
        if (rx_q.size() - r0 !== 1 || done_cnt - d0 !== 1) begin
            mismatched++; $display("FAIL min_preamble: got rx=%0d done=%0d expected 1 1", rx_q.size() - r0, done_cnt - d0);
        end else begin
            compared++;
            if (rx_q[r0] !== 8'h88) begin mismatched++; $display("FAIL min_preamble_byte: got %h expected 88", rx_q[r0]); end
        end
    endtask

    task automatic test_header_cut();
        int e0 = err_cnt;
        int d0 = done_cnt;
        repeat (28) send_dibit(2'b01);
        send_byte(8'hD5);
        send_byte(8'hF0); send_byte(8'h0D); send_byte(8'hDE);
        idle(3);
        compared++;
        if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL cut_in_dest: got err=%0d expected 0", err_cnt - e0); end
        repeat (28) send_dibit(2'b01);
        send_byte(8'hD5);
        for (int i = 0; i < 6; i++) send_byte(8'(48'hF00DDEADBEEF >> (40 - 8*i)));
        send_byte(8'h12); send_byte(8'h34);
        idle(3);
        compared++;
        if (err_cnt - e0 !== 1) begin mismatched++; $display("FAIL cut_in_src: got err=%0d expected 1", err_cnt - e0); end
        tx_q.delete();
        send_frame(28, 48'hF00DDEADBEEF, 16'h0806);
        idle(3);
        compared++;
        if (err_cnt - e0 !== 2 || done_cnt - d0 !== 0) begin
            mismatched++; $display("FAIL empty_payload: got err=%0d done=%0d expected 2 0", err_cnt - e0, done_cnt - d0);
        end
    endtask

    task automatic test_truncated();
        int r0 = rx_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        tx_q = '{8'hAB};
        send_frame(28, 48'hF00DDEADBEEF, 16'h0800);
        send_dibit(2'b11);
        send_dibit(2'b00);
        idle(3);
        compared++;
        if (rx_q.size() - r0 !== 1) begin mismatched++; $display("FAIL trunc_count: got %0d expected 1", rx_q.size() - r0); end
        else begin
            compared++;
            if (rx_q[r0] !== 8'hAB) begin mismatched++; $display("FAIL trunc_byte: got %h expected ab", rx_q[r0]); end
        end
        compared++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            mismatched++; $display("FAIL trunc_pulses: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0);
        end
        compared++;
        if (payload_len !== 11'd1) begin mismatched++; $display("FAIL trunc_len: got %0d expected 1", payload_len); end
    endtask

    task automatic test_back_to_back();
        int r0 = rx_q.size();
        int d0 = done_cnt;
        tx_q = '{8'h11};
        send_frame(28, 48'hF00DDEADBEEF, 16'h0800);
        idle(1);
        tx_q = '{8'h22, 8'h33};
        send_frame(28, 48'hF00DDEADBEEF, 16'h86DD);
        idle(3);
        compared++;
        if (done_cnt - d0 !== 2 || rx_q.size() - r0 !== 3) begin
            mismatched++; $display("FAIL b2b_counts: got done=%0d rx=%0d expected 2 3", done_cnt - d0, rx_q.size() - r0);
        end else begin
            compared++;
            if ({rx_q[r0], rx_q[r0+1], rx_q[r0+2]} !== 24'h112233) begin
                mismatched++; $display("FAIL b2b_bytes: got %h %h %h expected 11 22 33", rx_q[r0], rx_q[r0+1], rx_q[r0+2]);
            end
        end
        compared++;
        if ({payload_len, ethertype} !== {11'd2, 16'h86DD}) begin
            mismatched++; $display("FAIL b2b_status: got len=%0d type=%h expected 2 86dd", payload_len, ethertype);
        end
    endtask

    task automatic test_oversize();
        int r0 = rx_q.size();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int bad = 0;
        tx_q.delete();
        for (int i = 0; i < 1500; i++) tx_q.push_back(8'(i));
        send_frame(28, 48'hF00DDEADBEEF, 16'h0800);
        compared++;
        if (err_cnt - e0 !== 0) begin mismatched++; $display("FAIL over_early_err: got %0d expected 0", err_cnt - e0); end
        send_byte(8'hEE);
        compared++;
        if ({frame_err, axiov} !== 2'b10) begin
            mismatched++; $display("FAIL over_byte1501: got err=%b v=%b expected 1 0", frame_err, axiov);
        end
        send_byte(8'h01);
        send_byte(8'h02);
        idle(3);
        compared++;
        if (rx_q.size() - r0 !== 1500) begin mismatched++; $display("FAIL over_count: got %0d expected 1500", rx_q.size() - r0); end
        else begin
            for (int i = 0; i < 1500; i++) if (rx_q[r0+i] !== 8'(i)) bad++;
            compared++;
            if (bad !== 0) begin mismatched++; $display("FAIL over_bytes: got %0d wrong bytes expected 0", bad); end
        end
        compared++;
        if (err_cnt - e0 !== 1 || done_cnt - d0 !== 0) begin
            mismatched++; $display("FAIL over_pulses: got err=%0d done=%0d expected 1 0", err_cnt - e0, done_cnt - d0);
        end
        compared++;
        if (payload_len !== 11'd2) begin mismatched++; $display("FAIL over_len: got %0d expected 2", payload_len); end
    endtask

    task automatic test_reset_mid();
        int r0, d0, e0;
        tx_q = '{8'h10, 8'h20, 8'h30};
        send_frame(28, 48'hF00DDEADBEEF, 16'h0800);
        #1;
        rst = 1'b1;
        #1;
        compared++;
        if ({axiov, axiod, ethertype, payload_len} !== 36'd0) begin
            mismatched++; $display("FAIL rst_mid_outputs: got v=%b d=%h type=%h len=%0d expected all 0",
                                   axiov, axiod, ethertype, payload_len);
        end
        d0 = done_cnt;
        e0 = err_cnt;
        idle(2);
        rst = 1'b0;
        idle(3);
        compared++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
            mismatched++; $display("FAIL rst_mid_pulses: got done=%0d err=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
        end
        r0 = rx_q.size();
        tx_q = '{8'hC3, 8'hD4, 8'hE5};
        send_frame(16, 48'hF00DDEADBEEF, 16'h0801);
        idle(3);
        compared++;
        if (rx_q.size() - r0 !== 3 || done_cnt - d0 !== 1) begin
            mismatched++; $display("FAIL rst_after_frame: got rx=%0d done=%0d expected 3 1", rx_q.size() - r0, done_cnt - d0);
        end else begin
            compared++;
            if ({rx_q[r0], rx_q[r0+1], rx_q[r0+2]} !== 24'hC3D4E5) begin
                mismatched++; $display("FAIL rst_after_bytes: got %h %h %h expected c3 d4 e5", rx_q[r0], rx_q[r0+1], rx_q[r0+2]);
            end
        end
        compared++;
        if ({payload_len, ethertype} !== {11'd3, 16'h0801}) begin
            mismatched++; $display("FAIL rst_after_status: got len=%0d type=%h expected 3 0801", payload_len, ethertype);
        end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_filter();
        test_broadcast();
        test_preamble();
        test_header_cut();
        test_truncated();
        test_back_to_back();
        test_oversize();
        test_reset_mid();
        compared++;
        if (overlap_cnt !== 0) begin
            mismatched++; $display("FAIL pulse_overlap: got %0d overlapping cycles expected 0", overlap_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
